// File: rtl/inv_aes_iter_ctrl.sv
// ----------------------------------------------------------------------------
// inv_aes_iter_ctrl
//   Iterative AES-128 decryption sequencer. One key-schedule step, one
//   add-round-key and one inverse round are time-multiplexed by an FSM:
//   IDLE -> KEXP (10 cycles) -> ARK (1 cycle) -> RND (10 cycles) -> DONE.
//   Round keys rk[0..10] are kept in a register store, so a request that
//   reuses the previous key can skip expansion when KEY_CACHE is set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   in_cipher, in_key   ciphertext block and forward cipher key (rk[0])
//   in_key_same         request reuses the previous request's key
//   out_valid/out_ready result handshake; out_valid held until accepted
//   out_plain           decrypted block, keeps its value after handshake
//   busy                FSM not in IDLE
// ----------------------------------------------------------------------------
module inv_aes_iter_ctrl #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_cipher,
    input  logic [127:0] in_key,
    input  logic         in_key_same,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_plain,
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEXP, ST_ARK, ST_RND, ST_DONE
    } fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rk_d [0:10];
    logic           key_valid_q, key_valid_d;
    logic [127:0]   cipher_q, cipher_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   out_plain_q, out_plain_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic [127:0]   rnd_res;

    // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Undo the affine map first, then invert in the field
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // One forward key-schedule step: round key idx from round key idx-1
    function automatic logic [127:0] inv_keygen(input logic [3:0] idx, input logic [127:0] k);
        logic [7:0]  rcon;
        logic [31:0] w3;
        logic [31:0] tmp;
        logic [31:0] n0, n1, n2, n3;
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        w3  = k[31:0];
        tmp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0  = k[127:96] ^ tmp;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_add_round_keys(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    // InvShiftRows + InvSubBytes, add round key, then InvMixColumns except
    // in the last round. Byte b sits at bits [127-8b -: 8], row b%4, col b/4.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic last,
                                               input logic [127:0] k);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        t = inv_add_round_keys(t, k);
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                t[127-32*c -: 32] = {
                    gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                    gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                    gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                    gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
            end
        end
        return t;
    endfunction

    // Next-state logic. The round counter is only trusted in 1..10; any
    // other value in KEXP/RND sends the FSM back to IDLE.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        rk_d        = rk_q;
        key_valid_d = key_valid_q;
        cipher_d    = cipher_q;
        blk_d       = blk_q;
        out_plain_d = out_plain_q;
        out_valid_d = out_valid_q;
        rnd_res     = '0;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    cipher_d = in_cipher;
                    rk_d[0]  = in_key;
                    cnt_d    = 4'd1;
                    if (KEY_CACHE && in_key_same && key_valid_q) begin
                        fsm_d = ST_ARK;
                    end else begin
                        // rk[0] changes now, so the old schedule is stale until rebuilt
                        key_valid_d = 1'b0;
                        fsm_d       = ST_KEXP;
                    end
                end
            end
            ST_KEXP: begin
                if (cnt_q >= 4'd1 && cnt_q <= 4'd10) begin
                    rk_d[cnt_q] = inv_keygen(cnt_q, rk_q[cnt_q - 4'd1]);
                    if (cnt_q == 4'd10) begin
                        key_valid_d = KEY_CACHE;
                        fsm_d       = ST_ARK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_ARK: begin
                blk_d = inv_add_round_keys(cipher_q, rk_q[10]);
                cnt_d = 4'd1;
                fsm_d = ST_RND;
            end
            ST_RND: begin
                if (cnt_q >= 4'd1 && cnt_q <= 4'd10) begin
                    rnd_res = inv_round(blk_q, cnt_q == 4'd10, rk_q[4'd10 - cnt_q]);
                    blk_d   = rnd_res;
                    if (cnt_q == 4'd10) begin
                        out_plain_d = rnd_res;
                        out_valid_d = 1'b1;
                        fsm_d       = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        in_ready_d = (fsm_d == ST_IDLE);
        busy_d     = (fsm_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any operation at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 4'd0;
            rk_q        <= '{default: '0};
            key_valid_q <= 1'b0;
            cipher_q    <= '0;
            blk_q       <= '0;
            out_plain_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            rk_q        <= rk_d;
            key_valid_q <= key_valid_d;
            cipher_q    <= cipher_d;
            blk_q       <= blk_d;
            out_plain_q <= out_plain_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_plain = out_plain_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_aes_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_inv_aes_iter_ctrl
//   Drives two copies of the sequencer (key cache on and off) through known
//   FIPS-197 vectors, cache hits/misses, output back-pressure, back-to-back
//   requests, a mid-operation reset and random traffic. Expected plaintexts
//   come from constants or from an AES-128 encryption model in this file;
//   expected latencies come from a simple record of whether a key is cached.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inv_aes_iter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_key_same, out_ready, useNc;
    logic [127:0] in_cipher, in_key;
    logic         mainInValid, mainInReady, mainOutValid, mainBusy;
    logic         ncInValid, ncInReady, ncOutValid, ncBusy;
    logic [127:0] mainOutPlain, ncOutPlain;
    logic         rdy, ov, bz;
    logic [127:0] op;

    // Requests go to whichever copy useNc selects; its outputs are observed
    assign mainInValid = in_valid & ~useNc;
    assign ncInValid   = in_valid & useNc;
    assign rdy = useNc ? ncInReady    : mainInReady;
    assign ov  = useNc ? ncOutValid   : mainOutValid;
    assign bz  = useNc ? ncBusy       : mainBusy;
    assign op  = useNc ? ncOutPlain   : mainOutPlain;

    inv_aes_iter_ctrl #(.KEY_CACHE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(mainInValid), .in_ready(mainInReady),
        .in_cipher(in_cipher), .in_key(in_key), .in_key_same(in_key_same),
        .out_valid(mainOutValid), .out_ready(out_ready), .out_plain(mainOutPlain),
        .busy(mainBusy));

    inv_aes_iter_ctrl #(.KEY_CACHE(1'b0)) dutNc (
        .clk(clk), .rst_n(rst_n), .in_valid(ncInValid), .in_ready(ncInReady),
        .in_cipher(in_cipher), .in_key(in_key), .in_key_same(in_key_same),
        .out_valid(ncOutValid), .out_ready(out_ready), .out_plain(ncOutPlain),
        .busy(ncBusy));

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] cipher;
        logic         same;
        logic [127:0] plain;
    } vec_t;

    vec_t         vecs [0:4];
    logic [7:0]   sboxTab [0:255];
    int           checks = 0;
    int           errors = 0;
    bit           cacheValid = 1'b0;
    logic [127:0] lastKey = '0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_3  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    // Reference model: field multiply, S-box from brute-force inverses
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sboxTab[x] = s;
        end
    endtask

    // Forward AES-128 cipher on a byte array; used to manufacture ciphertexts
    function automatic logic [127:0] aesEncrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [7:0]   st [0:15];
        logic [7:0]   tmp [0:15];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sboxTab[t[23:16]] ^ rc, sboxTab[t[15:8]], sboxTab[t[7:0]], sboxTab[t[31:24]]};
                rc = gfMul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) tmp[b] = sboxTab[st[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gfMul(a0, 8'h02) ^ gfMul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gfMul(a1, 8'h02) ^ gfMul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gfMul(a2, 8'h02) ^ gfMul(a3, 8'h03);
                    st[4*c+3] = gfMul(a0, 8'h03) ^ a1 ^ a2 ^ gfMul(a3, 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for in_ready, transfers one request, scrambles the inputs and
    // counts cycles until out_valid (bounded); also watches in_ready/busy.
    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] cipher,
                                 input logic same, output int lat, output bit busyBad);
        int guard;
        guard = 0;
        busyBad = 1'b0;
        while (rdy !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checkOutput("in_ready_before_request", 128'(rdy), 128'(1));
        in_valid = 1'b1; in_key = key; in_cipher = cipher; in_key_same = same;
        @(posedge clk); #1;
        in_valid = 1'b0; in_key = rand128(); in_cipher = rand128(); in_key_same = 1'($urandom);
        lat = 0;
        while (ov !== 1'b1 && lat < 40) begin
            if (rdy !== 1'b0 || bz !== 1'b1) busyBad = 1'b1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finishHandshake(input string name, input logic [127:0] expPlain, input int holdCycles);
        bit unstable;
        unstable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            if (ov !== 1'b1 || op !== expPlain || rdy !== 1'b0) unstable = 1'b1;
        end
        if (holdCycles > 0) checkOutput({name, "_held_stable"}, 128'(unstable), 128'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, "_out_valid_dropped"}, 128'(ov), 128'(0));
        checkOutput({name, "_in_ready_after"}, 128'(rdy), 128'(1));
        checkOutput({name, "_plain_kept"}, op, expPlain);
    endtask

    // One full transaction with latency predicted from the cache record
    task automatic doRequest(input string name, input logic [127:0] key, input logic [127:0] cipher,
                             input logic same, input logic [127:0] expPlain, input int holdCycles);
        int lat, expLat;
        bit busyBad;
        expLat = (same && cacheValid && !useNc) ? 11 : 21;
        applyStimulus(key, cipher, same, lat, busyBad);
        checkOutput({name, "_latency"}, 128'(lat), 128'(expLat));
        checkOutput({name, "_plain"}, op, expPlain);
        checkOutput({name, "_busy_no_ready"}, 128'(busyBad), 128'(0));
        if (!useNc) begin
            cacheValid = 1'b1;
            lastKey = key;
        end
        finishHandshake(name, expPlain, holdCycles);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit early;
        logic [127:0] key, plain, pA, pB, cA, cB;
        logic same;

        buildSbox();
        vecs[0] = '{"fips_c1_first_same", KEY_C1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{"cache_hit_c1", KEY_C1, aesEncrypt(KEY_C1, 128'hffeeddccbbaa99887766554433221100), 1'b1,
                    128'hffeeddccbbaa99887766554433221100};
        vecs[2] = '{"fips_b_new_key", KEY_B, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[3] = '{"cache_hit_b", KEY_B, aesEncrypt(KEY_B, 128'h0123456789abcdeffedcba9876543210), 1'b1,
                    128'h0123456789abcdeffedcba9876543210};
        vecs[4] = '{"same_key_no_flag", KEY_B, aesEncrypt(KEY_B, 128'h00000000000000000000000000000001), 1'b0,
                    128'h00000000000000000000000000000001};

        useNc = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_key_same = 1'b0; in_key = '0; in_cipher = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 128'(rdy), 128'(0));
        checkOutput("reset_out_valid", 128'(ov), 128'(0));
        checkOutput("reset_busy", 128'(bz), 128'(0));
        checkOutput("reset_out_plain", op, 128'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_in_ready", 128'(rdy), 128'(1));
        checkOutput("release_busy", 128'(bz), 128'(0));

        for (int i = 0; i < 5; i++) begin
            doRequest(vecs[i].name, vecs[i].key, vecs[i].cipher, vecs[i].same, vecs[i].plain, 0);
        end

        // Back-pressure: result held for 50 cycles with out_ready low
        plain = 128'hdeadbeef0badf00dcafebabe12345678;
        doRequest("backpressure", KEY_B, aesEncrypt(KEY_B, plain), 1'b1, plain, 50);

        // Back-to-back: second request held on in_valid during the first
        pA = rand128(); pB = rand128();
        cA = aesEncrypt(KEY_B, pA); cB = aesEncrypt(KEY_B, pB);
        out_ready = 1'b1;
        in_valid = 1'b1; in_key = KEY_B; in_cipher = cA; in_key_same = 1'b1;
        @(posedge clk); #1;
        in_cipher = cB;
        lat = 0; early = 1'b0;
        while (ov !== 1'b1 && lat < 40) begin
            if (rdy !== 1'b0) early = 1'b1;
            @(posedge clk); #1; lat++;
        end
        checkOutput("b2b_first_latency", 128'(lat), 128'(11));
        checkOutput("b2b_first_plain", op, pA);
        checkOutput("b2b_no_accept_while_busy", 128'(early), 128'(0));
        @(posedge clk); #1;
        checkOutput("b2b_out_valid_dropped", 128'(ov), 128'(0));
        checkOutput("b2b_in_ready_rises", 128'(rdy), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_cipher = rand128();
        checkOutput("b2b_second_accepted", 128'(bz), 128'(1));
        lat = 0;
        while (ov !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checkOutput("b2b_second_latency", 128'(lat), 128'(11));
        checkOutput("b2b_second_plain", op, pB);
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("b2b_second_done", 128'(ov), 128'(0));

        // Random traffic: mix of cache hits and fresh keys
        for (int i = 0; i < 10; i++) begin
            plain = rand128();
            if (cacheValid && $urandom_range(0, 2) != 0) begin
                key = lastKey; same = 1'b1;
            end else begin
                key = rand128(); same = 1'b0;
            end
            doRequest($sformatf("random_%0d", i), key, aesEncrypt(key, plain), same, plain,
                      int'($urandom_range(0, 3)));
        end

        // Reset in the middle of the inverse rounds (round counter at 5)
        plain = rand128();
        in_valid = 1'b1; in_key = KEY_3; in_cipher = aesEncrypt(KEY_3, plain); in_key_same = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 128'(bz), 128'(0));
        checkOutput("midreset_in_ready", 128'(rdy), 128'(0));
        checkOutput("midreset_out_valid", 128'(ov), 128'(0));
        checkOutput("midreset_out_plain", op, 128'h0);
        cacheValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        doRequest("after_reset_same", KEY_3, aesEncrypt(KEY_3, plain), 1'b1, plain, 0);

        // Cache disabled: in_key_same never shortens the operation
        useNc = 1'b1;
        #1;
        doRequest("nocache_first", KEY_C1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
                  128'h00112233445566778899aabbccddeeff, 0);
        doRequest("nocache_same", KEY_C1, vecs[1].cipher, 1'b1, vecs[1].plain, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
